// File: rtl/ctrl_unit.sv
// Multicycle sequencer for the QISP core: fetch/decode/exec/mem/write-back control,
// queue front pointer and STOP/resume halt. Optional retired counter: CTRL_PERF_CNT_EN.
module ctrl_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ready,
  input  logic        is_stop,
  input  logic        op_type,
  input  logic [1:0]  sel_d,
  input  logic        rd_is_front,
  input  logic        q_dir,
  input  logic [3:0]  qp_data,
  input  logic        run,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_load,
  output logic        alu_en,
  output logic        rf_we,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [3:0]  q_front,
  output logic        halted,
  output logic [15:0] retired
);

  localparam int unsigned QW = 4;
  localparam int unsigned RW = 16;
  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_QP  = 2'b01;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t     state;
  logic       pc_inc_r;
  logic       store_c;
  logic [2:0] wb_strb_c;

  assign store_c   = (sel_d == SEL_QP);
  // {rf_we, pc_inc, pc_load} to present while in WB
  assign wb_strb_c = {(sel_d == SEL_REG), ~sel_d[1], sel_d[1]};

  // Acceptance-qualified pulses are combinational; reset suppresses them
  assign ir_load = ~rst & (state == FETCH) & mem_ready;
  assign pc_inc  = pc_inc_r
                 | (~rst & (state == MEM) & mem_ready & store_c)
                 | (~rst & (state == HALT) & run);

  // State register with Moore outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      q_front  <= QW'(0);
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      addr_sel <= 1'b0;
      alu_en   <= 1'b0;
      rf_we    <= 1'b0;
      pc_inc_r <= 1'b0;
      pc_load  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      addr_sel <= 1'b0;
      alu_en   <= 1'b0;
      rf_we    <= 1'b0;
      pc_inc_r <= 1'b0;
      pc_load  <= 1'b0;
      halted   <= 1'b0;
      unique case (state)
        IDLE: begin
          state   <= FETCH;
          mem_req <= 1'b1;
        end
        FETCH: begin
          if (mem_ready) begin
            state <= DECODE;
          end else begin
            mem_req <= 1'b1;
          end
        end
        DECODE: begin
          if (is_stop) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state  <= EXEC;
            alu_en <= 1'b1;
          end
        end
        EXEC: begin
          if (op_type) begin
            state    <= MEM;
            mem_req  <= 1'b1;
            addr_sel <= 1'b1;
            mem_we   <= store_c;
          end else begin
            state                       <= WB;
            {rf_we, pc_inc_r, pc_load}  <= wb_strb_c;
          end
        end
        MEM: begin
          if (mem_ready && store_c) begin
            state   <= FETCH;
            mem_req <= 1'b1;
          end else if (mem_ready) begin
            state                       <= WB;
            {rf_we, pc_inc_r, pc_load}  <= wb_strb_c;
          end else begin
            mem_req  <= 1'b1;
            addr_sel <= 1'b1;
            mem_we   <= store_c;
          end
        end
        WB: begin
          state   <= FETCH;
          mem_req <= 1'b1;
          if (sel_d == SEL_QP) begin
            q_front <= qp_data;
          end else if ((sel_d == SEL_REG) && rd_is_front) begin
            q_front <= q_dir ? q_front - QW'(1) : q_front + QW'(1);
          end
        end
        HALT: begin
          if (run) begin
            state   <= FETCH;
            mem_req <= 1'b1;
          end else begin
            halted <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic retire_c;

  assign retire_c = (state == WB) || ((state == MEM) && mem_ready && store_c);

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      retired <= RW'(0);
    end else if (retire_c) begin
      retired <= retired + RW'(1);
    end
  end
`else
  assign retired = RW'(0);
`endif

endmodule
